adsr_envelope: RTL

- Amplitude-envelope stage directly downstream of the oscillator.
- Consumes the oscillator's 16-bit unsigned wave (mid-scale 0x8000 = silence) and applies an attack/decay/sustain/release envelope driven by a note gate.
- Envelope updates once per sample strobe; the scaled wave feeds the mixer/DAC path.

---
 rtl/synth_pkg.sv | 16 +
 rtl/env_scaler.sv | 30 +++
 rtl/adsr_envelope.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared synth voice types: envelope state encoding and wave/level constants.
// Used by adsr_envelope and env_scaler.
package synth_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } adsr_state_t;

  localparam logic [15:0] WAVE_MID = 16'h8000;
  localparam logic [15:0] ENV_MAX  = 16'hFFFF;

endpackage

// File: rtl/env_scaler.sv
// Combinational offset-binary wave times unsigned level multiply.
// Output keeps the upper half of the signed product, re-offset to binary.
module env_scaler
  import synth_pkg::*;
#(
  parameter int WAVE_W = 16,
  parameter int ENV_W  = 16
) (
  input  logic [WAVE_W-1:0] i_wave,
  input  logic [ENV_W-1:0]  i_level,
  output logic [WAVE_W-1:0] o_wave
);

  localparam logic [WAVE_W-1:0] L_MID = WAVE_MID;

  logic signed [WAVE_W-1:0]       w_s;
  logic signed [ENV_W:0]          w_lvl;
  logic signed [WAVE_W+ENV_W:0]   w_p;
  logic                           w_unused;

  assign w_s   = $signed(i_wave ^ L_MID);
  assign w_lvl = $signed({1'b0, i_level});
  assign w_p   = w_s * w_lvl;

  assign o_wave = w_p[2*WAVE_W-1:WAVE_W] ^ L_MID;

  // Sign bit and fractional half are dropped by design
  assign w_unused = ^{w_p[WAVE_W+ENV_W:2*WAVE_W], w_p[WAVE_W-1:0]};

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope applied to the oscillator wave per sample tick.
// ADSR_VELOCITY_EN adds a velocity input and a second scaling stage.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int WAVE_W = 16,
  parameter int ENV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gate,
  input  logic              sample_tick,
  input  logic [ENV_W-1:0]  attack_step,
  input  logic [ENV_W-1:0]  decay_step,
  input  logic [ENV_W-1:0]  sustain_level,
  input  logic [ENV_W-1:0]  release_step,
`ifdef ADSR_VELOCITY_EN
  input  logic [6:0]        velocity,
`endif
  input  logic [WAVE_W-1:0] wave_in,
  output logic [WAVE_W-1:0] wave_out,
  output logic [ENV_W-1:0]  env_level,
  output logic              active
);

  localparam logic [WAVE_W-1:0] L_MID = WAVE_MID;
  localparam logic [ENV_W-1:0]  L_MAX = ENV_MAX;

  adsr_state_t       r_state;
  logic [ENV_W-1:0]  r_env;
  logic              r_active;
  logic [WAVE_W-1:0] r_wave;

  logic [ENV_W:0]    w_sum;
  logic [ENV_W:0]    w_dec;
  logic [ENV_W-1:0]  w_rel;
  logic              w_att_done;
  logic              w_dec_done;
  logic              w_rel_done;
  logic [WAVE_W-1:0] w_scaled;

  // One guard bit keeps saturation and underflow visible
  assign w_sum = {1'b0, r_env} + {1'b0, attack_step};
  assign w_dec = {1'b0, r_env} - {1'b0, decay_step};
  assign w_rel = r_env - release_step;

  assign w_att_done = (attack_step == '0)
                   || (w_sum >= {1'b0, L_MAX});
  assign w_dec_done = (decay_step == '0) || w_dec[ENV_W]
                   || (w_dec[ENV_W-1:0] <= sustain_level);
  assign w_rel_done = (release_step == '0)
                   || (r_env <= release_step);

  env_scaler #(
    .WAVE_W (WAVE_W),
    .ENV_W  (ENV_W)
  ) u_scale (
    .i_wave  (wave_in),
    .i_level (r_env),
    .o_wave  (w_scaled)
  );

`ifdef ADSR_VELOCITY_EN
  logic [6:0]        r_vel;
  logic [WAVE_W-1:0] r_wave2;
  logic [WAVE_W-1:0] w_vscaled;

  env_scaler #(
    .WAVE_W (WAVE_W),
    .ENV_W  (16)
  ) u_vel (
    .i_wave  (r_wave),
    .i_level ({r_vel, r_vel[6:0], 2'b11}),
    .o_wave  (w_vscaled)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wave2 <= L_MID;
    else       r_wave2 <= w_vscaled;
  end

  assign wave_out = r_wave2;
`else
  assign wave_out = r_wave;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_env    <= '0;
      r_active <= 1'b0;
      r_wave   <= L_MID;
`ifdef ADSR_VELOCITY_EN
      r_vel    <= '0;
`endif
    end else begin
      r_wave <= w_scaled;
      unique case (r_state)
        S_IDLE: begin
          if (gate) begin
            r_state  <= S_ATTACK;
            r_active <= 1'b1;
`ifdef ADSR_VELOCITY_EN
            r_vel    <= velocity;
`endif
          end
        end
        S_ATTACK: begin
          if (sample_tick) begin
            if (w_att_done) begin
              r_env   <= L_MAX;
              r_state <= S_DECAY;
            end else begin
              r_env   <= w_sum[ENV_W-1:0];
            end
          end
          // Gate release overrides the saturation move
          if (!gate) r_state <= S_RELEASE;
        end
        S_DECAY: begin
          if (sample_tick) begin
            if (w_dec_done) begin
              r_env   <= sustain_level;
              r_state <= S_SUSTAIN;
            end else begin
              r_env   <= w_dec[ENV_W-1:0];
            end
          end
          if (!gate) r_state <= S_RELEASE;
        end
        S_SUSTAIN: begin
          if (sample_tick) r_env <= sustain_level;
          if (!gate) r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (gate) begin
            r_state <= S_ATTACK;
`ifdef ADSR_VELOCITY_EN
            r_vel   <= velocity;
`endif
          end else if (sample_tick) begin
            if (w_rel_done) begin
              r_env    <= '0;
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else begin
              r_env    <= w_rel;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign env_level = r_env;
  assign active    = r_active;

endmodule
